// File: rtl/ss_reg_sequencer.sv
// -----------------------------------------------------------------------------
// ss_reg_sequencer
//
// Walks the shared 64-bit savestate register bus (10-bit index, one register
// per index) and moves every register to or from a block of savestate memory.
// It can also pulse the bus default-load strobe so that every module reloads
// its power-on value.
//
//   save : for idx 0..NUM_REGS-1, present idx on the bus, wait BUS_LAT cycles,
//          capture the read data, then write it to MEM_BASE + idx*8.
//   load : for idx 0..NUM_REGS-1, read MEM_BASE + idx*8, then write the word
//          onto the bus with a single-cycle write strobe.
//   dflt : one-cycle ss_rst pulse.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_start_save/load/dflt      single-cycle requests, sampled in IDLE only;
//                               priority dflt > save > load
//   o_busy                      high while an operation is in progress
//   o_done                      one-cycle pulse at the end of an operation
//   o_ss_adr, o_ss_din          bus index and write data
//   o_ss_wren, o_ss_rst         bus write strobe and default-load strobe
//   i_ss_dout                   wired-OR bus read data
//   o_mem_req/we/addr/wdata     memory request channel
//   i_mem_rdata, i_mem_ack      memory response
//   o_dbg_state                 current FSM state encoding
//
// Memory handshake: o_mem_req rises with o_mem_we/o_mem_addr/o_mem_wdata
// stable and stays high, with those fields unchanged, until the cycle in
// which i_mem_ack is sampled high; it drops on the following edge. An
// i_mem_ack seen while o_mem_req is low is ignored. i_mem_rdata is only
// taken in the acknowledge cycle of a read.
// -----------------------------------------------------------------------------
module ss_reg_sequencer #(
  parameter int          NUM_REGS = 64,
  parameter int          BUS_LAT  = 2,
  parameter logic [24:0] MEM_BASE = 25'd0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start_save,
  input  logic        i_start_load,
  input  logic        i_start_dflt,
  output logic        o_busy,
  output logic        o_done,
  output logic [9:0]  o_ss_adr,
  output logic [63:0] o_ss_din,
  output logic        o_ss_wren,
  output logic        o_ss_rst,
  input  logic [63:0] i_ss_dout,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [24:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DFLT   = 3'd1,
    ST_SV_ADR = 3'd2,
    ST_SV_MEM = 3'd3,
    ST_LD_MEM = 3'd4,
    ST_LD_WR  = 3'd5,
    ST_NEXT   = 3'd6,
    ST_FIN    = 3'd7
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(NUM_REGS - 1);
  localparam logic [2:0] LAT_LAST = 3'(BUS_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_idx;
  logic [9:0]  w_idx_nxt;
  logic [2:0]  r_lat_cnt;
  logic        r_load;
  logic [9:0]  r_ss_adr;
  logic [63:0] r_ss_din;
  logic [24:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic [24:0] w_addr_nxt;

  // Address of the slot the FSM is about to access; truncated to 25 bits.
  assign w_addr_nxt = MEM_BASE + {12'd0, w_idx_nxt, 3'b000};

  // ---------------------------------------------------------------------------
  // Next-state and decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next    = r_state;
    w_idx_nxt = r_idx;
    o_ss_wren = 1'b0;
    o_ss_rst  = 1'b0;
    o_done    = 1'b0;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_dflt) begin
          w_next    = ST_DFLT;
          w_idx_nxt = 10'd0;
        end else if (i_start_save) begin
          w_next    = ST_SV_ADR;
          w_idx_nxt = 10'd0;
        end else if (i_start_load) begin
          w_next    = ST_LD_MEM;
          w_idx_nxt = 10'd0;
        end
      end
      ST_DFLT: begin
        o_ss_rst = 1'b1;
        w_next   = ST_FIN;
      end
      ST_SV_ADR: begin
        // The last counted cycle is the one in which read data is valid.
        if (r_lat_cnt == LAT_LAST) begin
          w_next = ST_SV_MEM;
        end
      end
      ST_SV_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ack) begin
          w_next = ST_NEXT;
        end
      end
      ST_LD_MEM: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_next = ST_LD_WR;
        end
      end
      ST_LD_WR: begin
        o_ss_wren = 1'b1;
        w_next    = ST_NEXT;
      end
      ST_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_next = ST_FIN;
        end else begin
          w_idx_nxt = r_idx + 10'd1;
          w_next    = r_load ? ST_LD_MEM : ST_SV_ADR;
        end
      end
      ST_FIN: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, index and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= 10'd0;
      r_lat_cnt   <= 3'd0;
      r_load      <= 1'b0;
      r_ss_adr    <= 10'd0;
      r_ss_din    <= 64'd0;
      r_mem_addr  <= 25'd0;
      r_mem_wdata <= 64'd0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_nxt;

      // Mode is captured once at the start and steers NEXT for the whole walk.
      if (r_state == ST_IDLE && w_next != ST_IDLE) begin
        r_load <= (w_next == ST_LD_MEM);
      end

      r_lat_cnt <= (r_state == ST_SV_ADR) ? r_lat_cnt + 3'd1 : 3'd0;

      // ss_adr is loaded on entry to SV_ADR / LD_WR and held everywhere else.
      if (w_next == ST_SV_ADR && r_state != ST_SV_ADR) begin
        r_ss_adr <= w_idx_nxt;
      end
      if (w_next == ST_LD_WR) begin
        r_ss_adr <= r_idx;
      end

      // mem_addr is loaded on entry to a memory state so it stays stable
      // for the whole request.
      if ((w_next == ST_SV_MEM && r_state != ST_SV_MEM) ||
          (w_next == ST_LD_MEM && r_state != ST_LD_MEM)) begin
        r_mem_addr <= w_addr_nxt;
      end

      if (r_state == ST_SV_ADR && w_next == ST_SV_MEM) begin
        r_mem_wdata <= i_ss_dout;
      end

      if (r_state == ST_LD_MEM && i_mem_ack) begin
        r_ss_din <= i_mem_rdata;
      end
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_ss_adr    = r_ss_adr;
  assign o_ss_din    = r_ss_din;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_dbg_state = r_state;

endmodule
